row_loader: RTL and testbench

Stream-side writer for the convolution row engine. Accepts Q8.8 words on a valid/ready stream, fills an 8-tap kernel buffer and a 28-sample row buffer, then starts the engine. It waits for the engine's sticky `done`, pulses an engine clear, and returns to loading. It sits between the input stream source (UART/pixel front end) and one row engine instance, and drives that engine's operand buffers and control.

---
 rtl/cnn_pkg.sv | 36 +++
 rtl/row_loader_if.sv | 26 ++
 rtl/row_loader_job_framer.sv | 87 ++++++++
 rtl/row_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_row_loader.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared definitions for the convolution row engine and its
//                stream-side loader: default word width and job geometry,
//                the Q8.8 word type and the loader state encoding.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

   // Default job geometry; the row engine and loader both size from these.
   localparam int DATA_W_DEF = 16;  // Q8.8 signed word
   localparam int IN_LEN_DEF = 28;  // row samples per job
   localparam int K_DEF      = 8;   // kernel taps per job

   typedef logic signed [DATA_W_DEF-1:0] q88_t;

   typedef enum logic [2:0] {
      ST_LOAD_K = 3'd0,
      ST_LOAD_R = 3'd1,
      ST_START  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_CLEAR  = 3'd4,
      ST_DRAIN  = 3'd5
   } loader_state_t;

   // Index width able to address the larger of two buffers (minimum 1 bit).
   function automatic int idx_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage : cnn_pkg
`default_nettype wire

// File: rtl/row_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : row_loader_if
//  Description : Valid/ready word stream feeding the row loader.
//  Signals     : s_valid  - stream word valid         (master -> slave)
//                s_ready  - slave accepts this cycle  (slave  -> master)
//                s_data   - stream word, signed Q8.8  (master -> slave)
//                s_last   - final word of a job       (master -> slave)
//  Modports    : master (stream source), slave (row_loader)
//  Revision    : 1.0 - initial release
// ============================================================================
interface row_loader_if
   import cnn_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
);
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              s_last;

   modport master (output s_valid, output s_data, output s_last, input s_ready);
   modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface : row_loader_if
`default_nettype wire

// File: rtl/row_loader_job_framer.sv
`default_nettype none
// ============================================================================
//  Module      : job_framer
//  Description : Word index counter and framing checker for the row loader.
//                Tracks the position of the next word inside the buffer being
//                filled, flags the expected final row word and detects
//                s_last arriving early or missing on the final word.
//  Ports       : clk, rst       - clock, asynchronous active-high reset
//                xfer_i         - a stream word transfers this cycle
//                load_k_i       - loader is filling the kernel buffer
//                load_r_i       - loader is filling the row buffer
//                last_i         - s_last of the current word
//                word_idx_o     - index of the current word in its buffer
//                kern_end_o     - current word is the last kernel tap
//                is_final_o     - current word is the expected final row word
//                early_last_o   - s_last on a transferred non-final word
//                err_len_o      - sticky framing error
//  Revision    : 1.0 - initial release
// ============================================================================
module job_framer
   import cnn_pkg::*;
#(
   parameter int K      = K_DEF,
   parameter int IN_LEN = IN_LEN_DEF,
   parameter int IDX_W  = idx_width(K_DEF, IN_LEN_DEF)
)(
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             xfer_i,
   input  wire logic             load_k_i,
   input  wire logic             load_r_i,
   input  wire logic             last_i,
   output logic [IDX_W-1:0]      word_idx_o,
   output logic                  kern_end_o,
   output logic                  is_final_o,
   output logic                  early_last_o,
   output logic                  err_len_o
);

   localparam logic [IDX_W-1:0] KERN_LAST = IDX_W'(K - 1);
   localparam logic [IDX_W-1:0] ROW_LAST  = IDX_W'(IN_LEN - 1);

   logic [IDX_W-1:0] idx_q, idx_d;
   logic             err_q, err_d;
   logic             kern_end, is_final, early_last, late_miss;

   always_comb begin
      kern_end   = load_k_i && (idx_q == KERN_LAST);
      is_final   = load_r_i && (idx_q == ROW_LAST);
      // Any s_last in the kernel phase is early: a job always ends on a row word.
      early_last = xfer_i && last_i && (load_k_i || (load_r_i && !is_final));
      late_miss  = xfer_i && is_final && !last_i;

      idx_d = idx_q;
      if (!(load_k_i || load_r_i)) begin
         // Outside the fill phases the index parks at 0 so a new phase
         // (including a resume straight into the row phase) starts clean.
         idx_d = '0;
      end else if (xfer_i) begin
         if (kern_end || is_final || early_last) begin
            idx_d = '0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end

      err_d = err_q | early_last | late_miss;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= '0;
         err_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         err_q <= err_d;
      end
   end

   assign word_idx_o   = idx_q;
   assign kern_end_o   = kern_end;
   assign is_final_o   = is_final;
   assign early_last_o = early_last;
   assign err_len_o    = err_q;

endmodule : job_framer
`default_nettype wire

// File: rtl/row_loader.sv
`default_nettype none
// ============================================================================
//  Module      : row_loader
//  Description : Stream-side writer for the convolution row engine. Fills an
//                K-tap kernel buffer and an IN_LEN-sample row buffer from a
//                valid/ready word stream, starts the engine, waits for its
//                sticky done, pulses an engine clear and returns to loading.
//                Malformed jobs (s_last early or missing) raise a sticky
//                err_len and are discarded without starting the engine.
//  Ports       : clk, rst       - clock, asynchronous active-high reset
//                s_if           - stream slave (s_valid/s_ready/s_data/s_last)
//                kern_buf       - kernel taps, index 0 first received
//                row_buf        - row samples, index 0 first received
//                eng_start      - one-cycle engine start pulse
//                eng_done       - engine done level (sticky until cleared)
//                eng_clear      - one-cycle engine clear pulse
//                busy           - high from START through CLEAR
//                err_len        - sticky framing error
//                job_count      - completed jobs, wraps at 16 bits
//  Option      : ROW_LOADER_KEEP_KERNEL_EN - once a first job has completed
//                cleanly the kernel is retained; later jobs carry row words
//                only (IN_LEN words, s_last on row word IN_LEN-1).
//  Revision    : 1.0 - initial release
// ============================================================================
module row_loader
   import cnn_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IN_LEN = IN_LEN_DEF,
   parameter int K      = K_DEF
)(
   input  wire logic          clk,
   input  wire logic          rst,
   row_loader_if.slave        s_if,
   output logic [DATA_W-1:0]  kern_buf [K],
   output logic [DATA_W-1:0]  row_buf  [IN_LEN],
   output logic               eng_start,
   input  wire logic          eng_done,
   output logic               eng_clear,
   output logic               busy,
   output logic               err_len,
   output logic [15:0]        job_count
);

   localparam int IDX_W  = idx_width(K, IN_LEN);
   localparam int KIDX_W = idx_width(K, 1);
   localparam int RIDX_W = idx_width(IN_LEN, 1);

   loader_state_t     state_q, state_d;
   loader_state_t     resume_state;
   logic              ready_en_q;
   logic              busy_q;
   logic [15:0]       job_count_q;
   logic [DATA_W-1:0] kern_q [K];
   logic [DATA_W-1:0] row_q  [IN_LEN];

   logic              in_load_k, in_load_r, in_drain;
   logic              xfer;
   logic              start_c, clear_c;
   logic [IDX_W-1:0]  word_idx;
   logic              kern_end, is_final, early_last;

   // ------------------------------------------------------------------------
   // Stream handshake. ready_en_q holds s_ready low while rst is asserted
   // and for the first edge after release, even though the state register
   // already sits in LOAD_K.
   // ------------------------------------------------------------------------
   assign in_load_k     = (state_q == ST_LOAD_K);
   assign in_load_r     = (state_q == ST_LOAD_R);
   assign in_drain      = (state_q == ST_DRAIN);
   assign s_if.s_ready  = ready_en_q && (in_load_k || in_load_r || in_drain);
   assign xfer          = s_if.s_valid && s_if.s_ready;

   job_framer #(
      .K      (K),
      .IN_LEN (IN_LEN),
      .IDX_W  (IDX_W)
   ) u_framer (
      .clk          (clk),
      .rst          (rst),
      .xfer_i       (xfer),
      .load_k_i     (in_load_k),
      .load_r_i     (in_load_r),
      .last_i       (s_if.s_last),
      .word_idx_o   (word_idx),
      .kern_end_o   (kern_end),
      .is_final_o   (is_final),
      .early_last_o (early_last),
      .err_len_o    (err_len)
   );

   // ------------------------------------------------------------------------
   // Where a finished or abandoned job hands back to: kernel phase, or the
   // row phase once a kernel has been retained.
   // ------------------------------------------------------------------------
`ifdef ROW_LOADER_KEEP_KERNEL_EN
   logic kern_valid_q;

   // Set only by a job that reaches START, so a faulted first job leaves the
   // kernel marked invalid and the next job reloads it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kern_valid_q <= 1'b0;
      end else if (state_q == ST_START) begin
         kern_valid_q <= 1'b1;
      end
   end

   assign resume_state = kern_valid_q ? ST_LOAD_R : ST_LOAD_K;
`else
   assign resume_state = ST_LOAD_K;
`endif

   // ------------------------------------------------------------------------
   // Control FSM: next state and pulse outputs.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      start_c = 1'b0;
      clear_c = 1'b0;
      case (state_q)
         ST_LOAD_K: begin
            if (xfer) begin
               if (early_last) begin
                  state_d = resume_state;
               end else if (kern_end) begin
                  state_d = ST_LOAD_R;
               end
            end
         end
         ST_LOAD_R: begin
            if (xfer) begin
               if (early_last) begin
                  state_d = resume_state;
               end else if (is_final) begin
                  state_d = s_if.s_last ? ST_START : ST_DRAIN;
               end
            end
         end
         ST_START: begin
            start_c = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (eng_done) begin
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            clear_c = 1'b1;
            state_d = resume_state;
         end
         ST_DRAIN: begin
            if (xfer && s_if.s_last) begin
               state_d = resume_state;
            end
         end
         default: begin
            state_d = ST_LOAD_K;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State, status and counters. busy tracks the engine-owned window
   // START..CLEAR from the registered next state so it rises with eng_start.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_LOAD_K;
         ready_en_q  <= 1'b0;
         busy_q      <= 1'b0;
         job_count_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         ready_en_q <= 1'b1;
         busy_q     <= (state_d == ST_START) || (state_d == ST_WAIT) ||
                       (state_d == ST_CLEAR);
         if (state_q == ST_CLEAR) begin
            job_count_q <= job_count_q + 16'd1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Operand buffers, written in place. A discarded job may leave partial
   // contents behind; the engine only looks at them between START and CLEAR.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < K; i++) begin
            kern_q[i] <= '0;
         end
         for (int j = 0; j < IN_LEN; j++) begin
            row_q[j] <= '0;
         end
      end else if (xfer) begin
         if (in_load_k) begin
            kern_q[word_idx[KIDX_W-1:0]] <= s_if.s_data;
         end else if (in_load_r) begin
            row_q[word_idx[RIDX_W-1:0]] <= s_if.s_data;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < K; gi++) begin : g_kern_out
         assign kern_buf[gi] = kern_q[gi];
      end
      for (genvar gj = 0; gj < IN_LEN; gj++) begin : g_row_out
         assign row_buf[gj] = row_q[gj];
      end
   endgenerate

   assign eng_start = start_c;
   assign eng_clear = clear_c;
   assign busy      = busy_q;
   assign job_count = job_count_q;

endmodule : row_loader
`default_nettype wire

// File: tb/tb_row_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_row_loader
//  Description : Self-checking bench for row_loader. Expected engine starts
//                (cycle and full buffer images) are queued as each job is
//                driven and checked by a monitor when eng_start appears.
//                With ROW_LOADER_KEEP_KERNEL_EN defined the kernel-retention
//                sequence runs instead of the default sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_row_loader;
   import cnn_pkg::*;

   localparam int DW     = DATA_W_DEF;
   localparam int KT     = K_DEF;
   localparam int RL     = IN_LEN_DEF;
   localparam int CW     = RL * DW;
   typedef logic [CW-1:0] cw_t;

   typedef struct {
      int                 cyc;
      logic [KT*DW-1:0]   kern;
      logic [RL*DW-1:0]   row;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           eng_done;
   logic           eng_start, eng_clear, busy, err_len;
   logic [15:0]    job_count;
   logic [DW-1:0]  kern_buf [KT];
   logic [DW-1:0]  row_buf  [RL];

   row_loader_if #(.DATA_W(DW)) s_if ();

   row_loader #(.DATA_W(DW), .IN_LEN(RL), .K(KT)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_if      (s_if),
      .kern_buf  (kern_buf),
      .row_buf   (row_buf),
      .eng_start (eng_start),
      .eng_done  (eng_done),
      .eng_clear (eng_clear),
      .busy      (busy),
      .err_len   (err_len),
      .job_count (job_count)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_starts = 0;
   int   last_xfer_cyc = 0;
   exp_t sb_q[$];

   task automatic check(input string tag, input cw_t obs, input cw_t exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic timeout_fail(input string tag);
      n_cmp++;
      n_bad++;
      $error("FAIL %s: observed timeout expected event", tag);
   endtask

   // ---------------- monitor: pops the scoreboard on every start -----------
   exp_t             mon_e;
   logic [KT*DW-1:0] mon_k;
   logic [RL*DW-1:0] mon_r;
   always @(negedge clk) begin
      if (eng_start === 1'b1) begin
         n_starts++;
         for (int i = 0; i < KT; i++) mon_k[i*DW +: DW] = kern_buf[i];
         for (int j = 0; j < RL; j++) mon_r[j*DW +: DW] = row_buf[j];
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL unexpected_start: observed start at cycle %0d expected none", cyc);
         end else begin
            mon_e = sb_q.pop_front();
            check("start_cycle", cw_t'(cyc), cw_t'(mon_e.cyc));
            check("busy_at_start", cw_t'(busy), cw_t'(1'b1));
            check("kern_buf", cw_t'(mon_k), cw_t'(mon_e.kern));
            check("row_buf", cw_t'(mon_r), cw_t'(mon_e.row));
         end
      end
   end

   // ---------------- stimulus helpers ---------------------------------------
   task automatic xfer_word(input logic [DW-1:0] d, input logic l);
      int   t;
      logic rdy;
      t = 0;
      s_if.s_valid = 1'b1;
      s_if.s_data  = d;
      s_if.s_last  = l;
      do begin
         rdy = s_if.s_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!rdy && t < 50);
      if (!rdy) timeout_fail("xfer_ready");
      last_xfer_cyc = cyc;
   endtask

   task automatic send_job(input logic [DW-1:0] base, input int n,
                           input int last_at, input int gap_at);
      for (int i = 0; i < n; i++) begin
         if (i == gap_at) begin
            // Idle gap with junk data and s_last high: must not be taken.
            s_if.s_valid = 1'b0;
            s_if.s_data  = 16'hDEAD;
            s_if.s_last  = 1'b1;
            repeat (3) begin
               @(posedge clk);
               #1;
            end
         end
         xfer_word(DW'(base + DW'(i)), (i == last_at));
      end
      s_if.s_valid = 1'b0;
      s_if.s_last  = 1'b0;
   endtask

   task automatic expect_start(input logic [DW-1:0] kbase, input logic [DW-1:0] rbase);
      exp_t e;
      e.cyc = last_xfer_cyc;
      for (int i = 0; i < KT; i++) e.kern[i*DW +: DW] = DW'(kbase + DW'(i));
      for (int j = 0; j < RL; j++) e.row[j*DW +: DW]  = DW'(rbase + DW'(j));
      sb_q.push_back(e);
   endtask

   // Engine model: raise sticky done after 'delay' edges, drop it on clear.
   task automatic engine_run(input int delay, input logic [15:0] exp_count);
      int m;
      int t;
      t = 0;
      repeat (delay) @(posedge clk);
      if (delay > 0) #1;
      eng_done = 1'b1;
      // Done is only looked at in WAIT, entered on the edge after START.
      m = ((cyc + 1) > (last_xfer_cyc + 2)) ? (cyc + 1) : (last_xfer_cyc + 2);
      do begin
         @(negedge clk);
         t++;
      end while (eng_clear !== 1'b1 && t < 100);
      if (eng_clear !== 1'b1) begin
         timeout_fail("wait_clear");
      end else begin
         check("clear_cycle", cw_t'(cyc), cw_t'(m));
         check("busy_in_clear", cw_t'(busy), cw_t'(1'b1));
      end
      @(posedge clk);
      #1;
      eng_done = 1'b0;
      check("clear_width", cw_t'(eng_clear), cw_t'(1'b0));
      check("ready_after_clear", cw_t'(s_if.s_ready), cw_t'(1'b1));
      check("busy_after_clear", cw_t'(busy), cw_t'(1'b0));
      check("job_count", cw_t'(job_count), cw_t'(exp_count));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_s_ready"},   cw_t'(s_if.s_ready), cw_t'(1'b0));
      check({tag, "_eng_start"}, cw_t'(eng_start),    cw_t'(1'b0));
      check({tag, "_eng_clear"}, cw_t'(eng_clear),    cw_t'(1'b0));
      check({tag, "_busy"},      cw_t'(busy),         cw_t'(1'b0));
      check({tag, "_err_len"},   cw_t'(err_len),      cw_t'(1'b0));
      check({tag, "_job_count"}, cw_t'(job_count),    cw_t'(16'd0));
      check({tag, "_kern0"},     cw_t'(kern_buf[0]),  cw_t'(16'd0));
      check({tag, "_row_last"},  cw_t'(row_buf[RL-1]), cw_t'(16'd0));
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("ready_after_reset", cw_t'(s_if.s_ready), cw_t'(1'b1));
   endtask

   // ---------------- directed sequence --------------------------------------
   initial begin
      rst          = 1'b1;
      eng_done     = 1'b0;
      s_if.s_valid = 1'b0;
      s_if.s_data  = '0;
      s_if.s_last  = 1'b0;
      @(posedge clk);
      #1;
      check_reset_values("reset");
      release_reset();

`ifdef ROW_LOADER_KEEP_KERNEL_EN
      // Full first job, then a row-only job reusing the kernel.
      send_job(16'h0100, KT + RL, KT + RL - 1, -1);
      expect_start(16'h0100, 16'h0108);
      engine_run(5, 16'd1);
      send_job(16'h0800, RL, RL - 1, -1);
      expect_start(16'h0100, 16'h0800);
      engine_run(3, 16'd2);
      check("start_count", cw_t'(n_starts), cw_t'(2));
`else
      // Clean job.
      send_job(16'h0100, KT + RL, KT + RL - 1, -1);
      expect_start(16'h0100, 16'h0108);
      engine_run(5, 16'd1);
      check("err_clean", cw_t'(err_len), cw_t'(1'b0));

      // Same job with a valid gap mid-load.
      send_job(16'h0100, KT + RL, KT + RL - 1, 12);
      expect_start(16'h0100, 16'h0108);
      engine_run(3, 16'd2);

      // Early s_last on word 10: discarded, next job from kernel index 0.
      send_job(16'h0200, 11, 10, -1);
      @(posedge clk);
      #1;
      check("err_early", cw_t'(err_len), cw_t'(1'b1));
      check("busy_early", cw_t'(busy), cw_t'(1'b0));
      check("count_early", cw_t'(job_count), cw_t'(16'd2));
      send_job(16'h0300, KT + RL, KT + RL - 1, -1);
      expect_start(16'h0300, 16'h0308);
      engine_run(2, 16'd3);

      // Missing s_last: words 36..40 drained, recovery in the kernel phase.
      send_job(16'h0400, 41, 40, -1);
      check("ready_after_drain", cw_t'(s_if.s_ready), cw_t'(1'b1));
      check("busy_after_drain", cw_t'(busy), cw_t'(1'b0));
      check("count_drain", cw_t'(job_count), cw_t'(16'd3));
      check("starts_before_f", cw_t'(n_starts), cw_t'(3));
      // Done raised during START: ignored there, taken on WAIT entry.
      send_job(16'h0500, KT + RL, KT + RL - 1, -1);
      expect_start(16'h0500, 16'h0508);
      engine_run(0, 16'd4);

      // Reset while waiting on the engine.
      send_job(16'h0600, KT + RL, KT + RL - 1, -1);
      expect_start(16'h0600, 16'h0608);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("busy_in_wait", cw_t'(busy), cw_t'(1'b1));
      rst = 1'b1;
      #1;
      check_reset_values("rst_in_wait");
      release_reset();
      send_job(16'h0700, KT + RL, KT + RL - 1, -1);
      expect_start(16'h0700, 16'h0708);
      engine_run(4, 16'd1);
      check("err_after_rst", cw_t'(err_len), cw_t'(1'b0));
      check("start_count", cw_t'(n_starts), cw_t'(6));
`endif

      repeat (2) @(posedge clk);
      #1;
      check("scoreboard_empty", cw_t'(sb_q.size()), cw_t'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no completion expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_row_loader
`default_nettype wire
